circle_seg_animator: RTL and testbench
======================================

// Module: circle_seg_animator
// PURPOSE
//  Consumes the one-cycle overflow ticks of the prescaler counters and drives a multiplexed
//  NUM_DIGITS 7-segment display with a "circle" running around its outer ring.
//  - step_i (slow tick) advances the lit head one ring position.
//  - scan_i (fast tick) rotates the active digit.
//  Sits between the prescaler counters and the board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS  4  digits on the display; ring length P = 2*NUM_DIGITS+4
//  TRAIL       3  lit segments (head + TRAIL-1 behind it); legal range 1..P-1
//  ACTIVE_LOW  1  1: an_o/seg_o active-low; 0: active-high
// PORTS
//  clk_i     in   1                   system clock
//  rst_i     in   1                   synchronous, active-high reset
//  step_i    in   1                   animation tick; each rising edge counts once
//  scan_i    in   1                   multiplex tick; each rising edge counts once
//  run_i     in   1                   level; 1 = animate, 0 = blank and park
//  freeze_i  in   1                   level; 1 = hold current frame (display stays lit)
//  dir_i     in   1                   0 = clockwise (pos+1), 1 = counter-clockwise (pos-1)
//  pos_o     out  $clog2(P)           head position 0..P-1
//  wrap_o    out  1                   one-cycle pulse when head passes P-1 <-> 0
//  an_o      out  NUM_DIGITS          digit enables, one-hot active
//  seg_o     out  7                   segments {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Clock and reset:
//  - Single clock clk_i; reset is synchronous and active-high (rst_i).
//  Reset:
//  - state=IDLE, pos_o=0, wrap_o=0, scan digit=0.
//  - an_o, seg_o all inactive (all 1s when ACTIVE_LOW=1).
//  - Edge-detect history regs cleared to 0: a step_i/scan_i already high as reset releases counts as an edge.
//  Ticks:
//  - Rising edge = in & ~in_q. A tick held high N cycles counts once.
//  - Back-to-back 1-cycle pulses (1,0,1) count twice.
//  Ring mapping, digit 0 leftmost, clockwise order:
//  - pos 0..N-1       -> a of digit pos
//  - pos N, N+1       -> b, c of digit N-1
//  - pos N+2..2N+1    -> d of digit 2N+1-pos
//  - pos 2N+2, 2N+3   -> e, f of digit 0
//  FSM:
//  - IDLE -> RUN when run_i=1.
//  - RUN -> FREEZE when freeze_i=1.
//  - FREEZE -> RUN when freeze_i=0.
//  - RUN/FREEZE -> IDLE whenever run_i=0 (priority over freeze_i).
//  - Entering IDLE forces pos_o=0; display blank in IDLE.
//  Stepping (RUN only):
//  - A step edge in cycle k updates pos_o at the clock edge ending k; new value visible in cycle k+1.
//  - CW: P-1 -> 0; CCW: 0 -> P-1. Either wrap raises wrap_o for exactly that one cycle (k+1).
//  - Step edges in IDLE/FREEZE are dropped, not queued.
//  - A step edge in the cycle run_i falls is dropped.
//  - dir_i is sampled at the step edge; a change applies from the next step.
//  Trail:
//  - Lit set = {pos - s*i mod P, i = 0..TRAIL-1}, s = +1 CW, -1 CCW.
//  - The trail always lies behind the head and follows the current dir_i.
//  Scan:
//  - Each scan edge advances the digit 0..N-1, wrapping N-1 -> 0.
//  - Scan runs in every state, including IDLE (blank segments).
//  - an_o/seg_o are registered: they reflect the digit/pos of the previous cycle (1-cycle latency).
//  - Exactly one an_o bit is active outside reset; in IDLE seg_o is all-off.
//  Simultaneous step and scan edges in the same cycle: both take effect.
// STRUCTURE
//  circle7seg_pkg:
//  - SEG_A..SEG_G bit indices, typedef seg_t (logic [6:0]).
//  - FSM enum anim_state_e {IDLE, RUN, FREEZE}.
//  - function ring_to_seg(pos, N) returning {digit, segment}.
//  Sub-module tick_edge: registered rising-edge detector, instantiated for step_i and scan_i.
// TESTING (N=4, P=12, TRAIL=3, ACTIVE_LOW=1)
//  1 Reset, run_i=0 -> pos_o=0, wrap_o=0, seg_o=7'h7F every cycle.
//    Then scan pulses -> an_o steps 1110,1101,1011,0111,1110.
//  2 run_i=1, dir_i=0, 12 step pulses -> pos_o 1..11,0.
//    wrap_o high only in the cycle pos_o becomes 0.
//    At pos_o=0 the lit set is {0,11,10}.
//  3 dir_i=1 from pos_o=0, one step -> pos_o=11 and wrap_o=1.
//    At pos_o=11 the lit set is {11,0,1}.
//    Digit 0 shows segments a and f lit: seg_o=7'b1011110.
//  4 step_i held high 10 cycles -> pos_o advances by exactly 1.
//    Pulses 1,0,1 -> pos_o advances by 2.
//  5 freeze_i=1 at pos_o=5, 3 steps -> pos_o stays 5, display lit.
//    freeze_i=0, then one step -> pos_o=6.
//  6 run_i=0 at pos_o=7 in the same cycle as a step edge -> next cycle IDLE, pos_o=0, seg_o blank.
//    rst_i asserted mid-RUN -> all reset values the next cycle.

Source files
------------

// File: rtl/circle7seg_pkg.sv
// Shared types and ring geometry for the 7-segment circle animator.
//   SEG_A..SEG_G : bit index of each segment inside seg_t ({g,f,e,d,c,b,a})
//   seg_t        : one digit's segment vector
//   anim_state_e : animator FSM states
//   ring_to_seg  : maps a clockwise ring position to {digit, segment}
package circle7seg_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FREEZE
    } anim_state_e;

    typedef struct packed {
        logic [7:0] digit;
        logic [2:0] seg;
    } ring_loc_t;

    // Clockwise around the outer ring: top row left->right, right side down,
    // bottom row right->left, left side up. Digit 0 is leftmost.
    function automatic ring_loc_t ring_to_seg(input int unsigned pos, input int unsigned n);
        ring_loc_t loc;
        if (pos < n) begin
            loc.digit = 8'(pos);
            loc.seg   = 3'(SEG_A);
        end else if (pos == n) begin
            loc.digit = 8'(n - 1);
            loc.seg   = 3'(SEG_B);
        end else if (pos == n + 1) begin
            loc.digit = 8'(n - 1);
            loc.seg   = 3'(SEG_C);
        end else if (pos <= 2 * n + 1) begin
            loc.digit = 8'(2 * n + 1 - pos);
            loc.seg   = 3'(SEG_D);
        end else if (pos == 2 * n + 2) begin
            loc.digit = 8'd0;
            loc.seg   = 3'(SEG_E);
        end else begin
            loc.digit = 8'd0;
            loc.seg   = 3'(SEG_F);
        end
        return loc;
    endfunction

endpackage

// File: rtl/circle_seg_animator_tick_edge.sv
// Rising-edge detector for a prescaler tick: one history register, combinational edge.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (history cleared to 0)
//   tick   : incoming tick level
//   rise_c : high for the cycle in which tick is 1 and was 0 last cycle
module tick_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick,
    output logic rise_c
);

    logic tick_q;

    // History register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign rise_c = tick & ~tick_q;

endmodule

// File: rtl/circle_seg_animator.sv
// Drives a multiplexed 7-segment display with a lit trail running around its outer ring.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   step_i, scan_i    : animation / multiplex ticks (rising edge counts once)
//   run_i, freeze_i   : animate enable / hold current frame
//   dir_i             : 0 clockwise, 1 counter-clockwise
//   pos_o, wrap_o     : head position and one-cycle wrap pulse
//   an_o, seg_o       : registered digit enables and segments {g,f,e,d,c,b,a}
module circle_seg_animator
    import circle7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TRAIL      = 3,
    parameter bit          ACTIVE_LOW = 1'b1,
    localparam int unsigned P  = 2 * NUM_DIGITS + 4,
    localparam int unsigned PW = $clog2(P)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  step_i,
    input  logic                  scan_i,
    input  logic                  run_i,
    input  logic                  freeze_i,
    input  logic                  dir_i,
    output logic [PW-1:0]         pos_o,
    output logic                  wrap_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output seg_t                  seg_o
);

    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  step_c;
    logic                  scan_c;
    anim_state_e           state_q;
    anim_state_e           state_d;
    logic [PW-1:0]         pos_d;
    logic                  wrap_d;
    logic [DW-1:0]         dig_q;
    logic [DW-1:0]         dig_d;
    logic [NUM_DIGITS-1:0] an_d;
    seg_t                  seg_d;

    tick_edge u_step_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick   (step_i),
        .rise_c (step_c)
    );

    tick_edge u_scan_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick   (scan_i),
        .rise_c (scan_c)
    );

    // Next state, head position and wrap pulse
    always_comb begin
        state_d = state_q;
        pos_d   = pos_o;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE:    if (run_i) state_d = RUN;
            RUN:     if (!run_i) state_d = IDLE; else if (freeze_i) state_d = FREEZE;
            FREEZE:  if (!run_i) state_d = IDLE; else if (!freeze_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (state_q == RUN && run_i && step_c) begin
            if (dir_i) begin
                if (pos_o == '0) begin
                    pos_d  = PW'(P - 1);
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_o - PW'(1);
                end
            end else begin
                if (pos_o == PW'(P - 1)) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_o + PW'(1);
                end
            end
        end
        // Parking at 0 also swallows a step edge coincident with run_i falling
        if (state_d == IDLE) begin
            pos_d  = '0;
            wrap_d = 1'b0;
        end
    end

    // Scan digit counter
    always_comb begin
        dig_d = dig_q;
        if (scan_c) begin
            dig_d = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
        end
    end

    // Segment image of the scanned digit; trail sits behind the head for the current dir_i.
    // Blanking keys off the next state so the frame goes dark together with the park.
    always_comb begin
        seg_t        lit;
        int unsigned p;
        ring_loc_t   loc;
        lit = '0;
        p   = 0;
        loc = '0;
        for (int unsigned i = 0; i < TRAIL; i++) begin
            p   = dir_i ? (32'(pos_o) + i) % P : (32'(pos_o) + P - i) % P;
            loc = ring_to_seg(p, NUM_DIGITS);
            if (loc.digit == 8'(dig_q)) lit[loc.seg] = 1'b1;
        end
        if (state_d == IDLE) lit = '0;
        an_d  = NUM_DIGITS'(1) << dig_q;
        seg_d = ACTIVE_LOW ? ~lit : lit;
        if (ACTIVE_LOW) an_d = ~an_d;
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pos_o   <= '0;
            wrap_o  <= 1'b0;
            dig_q   <= '0;
            an_o    <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_o   <= {7{ACTIVE_LOW}};
        end else begin
            state_q <= state_d;
            pos_o   <= pos_d;
            wrap_o  <= wrap_d;
            dig_q   <= dig_d;
            an_o    <= an_d;
            seg_o   <= seg_d;
        end
    end

endmodule

// File: tb/tb_circle_seg_animator.sv
// Directed bench for circle_seg_animator with N=4 (P=12), TRAIL=3, active-low outputs.
module tb_circle_seg_animator;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       step_i;
    logic       scan_i;
    logic       run_i;
    logic       freeze_i;
    logic       dir_i;
    logic [3:0] pos_o;
    logic       wrap_o;
    logic [3:0] an_o;
    logic [6:0] seg_o;

    int checks = 0;
    int errors = 0;

    circle_seg_animator #(
        .NUM_DIGITS (4),
        .TRAIL      (3),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .step_i   (step_i),
        .scan_i   (scan_i),
        .run_i    (run_i),
        .freeze_i (freeze_i),
        .dir_i    (dir_i),
        .pos_o    (pos_o),
        .wrap_o   (wrap_o),
        .an_o     (an_o),
        .seg_o    (seg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_step();
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        cyc();
    endtask

    task automatic pulse_scan();
        scan_i = 1'b1;
        cyc();
        scan_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; step_i = 1'b0; scan_i = 1'b0;
        run_i = 1'b0; freeze_i = 1'b0; dir_i = 1'b0;
        cyc(); cyc();
        checks++; if (pos_o !== 4'd0)       begin errors++; $display("FAIL reset_pos got %0d exp 0", pos_o); end
        checks++; if (wrap_o !== 1'b0)      begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap_o); end
        checks++; if (an_o !== 4'b1111)     begin errors++; $display("FAIL reset_an got %b exp 1111", an_o); end
        checks++; if (seg_o !== 7'h7F)      begin errors++; $display("FAIL reset_seg got %h exp 7f", seg_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] an_exp [5];
        an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) pulse_scan();
            checks++; if (an_o !== an_exp[k]) begin errors++; $display("FAIL idle_an[%0d] got %b exp %b", k, an_o, an_exp[k]); end
            checks++; if (seg_o !== 7'h7F)    begin errors++; $display("FAIL idle_seg[%0d] got %h exp 7f", k, seg_o); end
            checks++; if (pos_o !== 4'd0)     begin errors++; $display("FAIL idle_pos[%0d] got %0d exp 0", k, pos_o); end
        end
    endtask

    task automatic test_cw();
        run_i = 1'b1;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            step_i = 1'b1;
            cyc();
            checks++; if (pos_o !== 4'(k % 12))   begin errors++; $display("FAIL cw_pos[%0d] got %0d exp %0d", k, pos_o, k % 12); end
            checks++; if (wrap_o !== (k == 12))   begin errors++; $display("FAIL cw_wrap[%0d] got %b exp %b", k, wrap_o, k == 12); end
            step_i = 1'b0;
            cyc();
            checks++; if (wrap_o !== 1'b0)        begin errors++; $display("FAIL cw_wrap_clr[%0d] got %b exp 0", k, wrap_o); end
        end
        checks++; if (seg_o !== 7'h4E)  begin errors++; $display("FAIL cw_trail_seg got %h exp 4e", seg_o); end
        checks++; if (an_o !== 4'b1110) begin errors++; $display("FAIL cw_an got %b exp 1110", an_o); end
    endtask

    task automatic test_ccw();
        dir_i = 1'b1;
        step_i = 1'b1;
        cyc();
        checks++; if (pos_o !== 4'd11) begin errors++; $display("FAIL ccw_pos got %0d exp 11", pos_o); end
        checks++; if (wrap_o !== 1'b1) begin errors++; $display("FAIL ccw_wrap got %b exp 1", wrap_o); end
        step_i = 1'b0;
        cyc();
        checks++; if (wrap_o !== 1'b0)       begin errors++; $display("FAIL ccw_wrap_clr got %b exp 0", wrap_o); end
        checks++; if (seg_o !== 7'b1011110)  begin errors++; $display("FAIL ccw_trail_seg got %b exp 1011110", seg_o); end
    endtask

    task automatic test_hold();
        dir_i = 1'b0;
        step_i = 1'b1;
        repeat (10) cyc();
        step_i = 1'b0;
        cyc();
        checks++; if (pos_o !== 4'd0) begin errors++; $display("FAIL hold_pos got %0d exp 0", pos_o); end
        step_i = 1'b1; cyc();
        step_i = 1'b0; cyc();
        step_i = 1'b1; cyc();
        step_i = 1'b0; cyc();
        checks++; if (pos_o !== 4'd2) begin errors++; $display("FAIL b2b_pos got %0d exp 2", pos_o); end
    endtask

    task automatic test_freeze();
        repeat (3) pulse_step();
        checks++; if (pos_o !== 4'd5) begin errors++; $display("FAIL frz_start_pos got %0d exp 5", pos_o); end
        freeze_i = 1'b1;
        cyc();
        repeat (3) pulse_step();
        checks++; if (pos_o !== 4'd5) begin errors++; $display("FAIL frz_hold_pos got %0d exp 5", pos_o); end
        repeat (3) pulse_scan();
        checks++; if (an_o !== 4'b0111) begin errors++; $display("FAIL frz_an got %b exp 0111", an_o); end
        checks++; if (seg_o !== 7'h78)  begin errors++; $display("FAIL frz_seg got %h exp 78", seg_o); end
        freeze_i = 1'b0;
        cyc();
        pulse_step();
        checks++; if (pos_o !== 4'd6) begin errors++; $display("FAIL frz_resume_pos got %0d exp 6", pos_o); end
    endtask

    task automatic test_run_fall();
        pulse_step();
        checks++; if (pos_o !== 4'd7)  begin errors++; $display("FAIL fall_pre_pos got %0d exp 7", pos_o); end
        checks++; if (seg_o !== 7'h73) begin errors++; $display("FAIL fall_pre_seg got %h exp 73", seg_o); end
        run_i = 1'b0;
        step_i = 1'b1;
        cyc();
        checks++; if (pos_o !== 4'd0)   begin errors++; $display("FAIL fall_pos got %0d exp 0", pos_o); end
        checks++; if (seg_o !== 7'h7F)  begin errors++; $display("FAIL fall_seg got %h exp 7f", seg_o); end
        checks++; if (wrap_o !== 1'b0)  begin errors++; $display("FAIL fall_wrap got %b exp 0", wrap_o); end
        checks++; if (an_o !== 4'b0111) begin errors++; $display("FAIL fall_an got %b exp 0111", an_o); end
        step_i = 1'b0;
        cyc();
        pulse_step();
        checks++; if (pos_o !== 4'd0) begin errors++; $display("FAIL idle_step_pos got %0d exp 0", pos_o); end
    endtask

    task automatic test_reset_mid_run();
        run_i = 1'b1;
        cyc();
        pulse_step();
        checks++; if (pos_o !== 4'd1) begin errors++; $display("FAIL mid_pre_pos got %0d exp 1", pos_o); end
        rst_i = 1'b1;
        cyc();
        checks++; if (pos_o !== 4'd0)   begin errors++; $display("FAIL mid_rst_pos got %0d exp 0", pos_o); end
        checks++; if (wrap_o !== 1'b0)  begin errors++; $display("FAIL mid_rst_wrap got %b exp 0", wrap_o); end
        checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL mid_rst_an got %b exp 1111", an_o); end
        checks++; if (seg_o !== 7'h7F)  begin errors++; $display("FAIL mid_rst_seg got %h exp 7f", seg_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_i = 1'b1;
        cyc();
        step_i = 1'b1;
        scan_i = 1'b1;
        cyc();
        checks++; if (pos_o !== 4'd1) begin errors++; $display("FAIL simul_pos got %0d exp 1", pos_o); end
        step_i = 1'b0;
        scan_i = 1'b0;
        cyc();
        checks++; if (an_o !== 4'b1101) begin errors++; $display("FAIL simul_an got %b exp 1101", an_o); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_cw();
        test_ccw();
        test_hold();
        test_freeze();
        test_run_fall();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
